// File: rtl/sm83_opcode_fetch_if.sv
// ----------------------------------------------------------------------------
// sm83_opcode_fetch_if
//
// Purpose:
//   Groups the bus/sequencer handshake and the decoder-facing outputs of the
//   SM83 opcode fetch front end into one bundle.
//
// Signals (direction as seen from the fetch unit, i.e. the slave modport):
//   data_in      in   8  data bus byte
//   data_valid   in   1  data_in valid this cycle (one byte per pulse)
//   instr_end    in   1  last cycle of the current instruction
//   irq          in   1  any enabled interrupt pending
//   ime          in   1  interrupt master enable (HALT bug build only)
//   m1           out  1  opcode fetch requested
//   opcode       out  8  latched opcode to the decoder
//   bank_cb      out  1  opcode belongs to the CB-prefixed bank
//   opcode_valid out  1  opcode/bank_cb stable and executing
//   in_halt      out  1  CPU halted
//   in_alu       out  1  ALU execute cycle of an ALU-class instruction
//   pc_hold      out  1  sequencer must not increment PC on this fetch
//
// Modports:
//   master - sequencer / bus side (drives data and control, reads decoder outputs)
//   slave  - the opcode fetch unit
// ----------------------------------------------------------------------------
interface sm83_opcode_fetch_if;
    localparam int WORD_SIZE = 8;

    logic [WORD_SIZE-1:0] data_in;
    logic                 data_valid;
    logic                 instr_end;
    logic                 irq;
    logic                 ime;

    logic                 m1;
    logic [WORD_SIZE-1:0] opcode;
    logic                 bank_cb;
    logic                 opcode_valid;
    logic                 in_halt;
    logic                 in_alu;
    logic                 pc_hold;

    modport master (
        output data_in, data_valid, instr_end, irq, ime,
        input  m1, opcode, bank_cb, opcode_valid, in_halt, in_alu, pc_hold
    );

    modport slave (
        input  data_in, data_valid, instr_end, irq, ime,
        output m1, opcode, bank_cb, opcode_valid, in_halt, in_alu, pc_hold
    );
endinterface

// File: rtl/sm83_opcode_fetch.sv
// ----------------------------------------------------------------------------
// sm83_opcode_fetch
//
// Purpose:
//   SM83 front end that produces the decoder's inputs. It latches opcode bytes
//   from the data bus, tracks the CB prefix bank and the HALT state, and pulses
//   in_alu during the ALU execute cycle of ALU-class instructions.
//
// Ports:
//   clk    in  1  system clock, all state on the rising edge
//   reset  in  1  asynchronous, active-high reset
//   bus    slave modport of sm83_opcode_fetch_if (data bus, sequencer
//                 handshake, decoder-facing outputs)
//
// Configuration:
//   SM83_HALT_BUG_EN  When defined, a HALT executed with ime=0 while an
//                     interrupt is already pending does not halt; the CPU goes
//                     straight back to fetch with pc_hold=1 until the next
//                     opcode byte is accepted, so the sequencer fetches that
//                     byte twice. When undefined, pc_hold is tied low, ime is
//                     unused and HALT is always entered.
//
// Outputs m1 and opcode_valid decode directly from the state register; every
// other output is registered.
// ----------------------------------------------------------------------------
module sm83_opcode_fetch (
    input  logic                  clk,
    input  logic                  reset,
    sm83_opcode_fetch_if.slave    bus
);

    localparam int WORD_SIZE = 8;

    localparam logic [WORD_SIZE-1:0] OP_PREFIX_CB = 8'hCB;
    localparam logic [WORD_SIZE-1:0] OP_HALT      = 8'h76;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_CB_FETCH = 2'd1,
        ST_EXEC     = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] opcode_q, opcode_d;
    logic                 bank_cb_q, bank_cb_d;
    logic                 in_halt_q, in_halt_d;
    logic                 in_alu_q, in_alu_d;
    logic                 pc_hold_q, pc_hold_d;
    // Set by the first data_valid of EXEC; limits the (HL)/n form to one pulse.
    logic                 operand_seen_q, operand_seen_d;

    // Bank-0 ALU class: 0x80-0xBF (r and (HL) forms) plus the immediate group
    // 0xC6, 0xCE, ... 0xFE. Caller applies the bank_cb qualification.
    function automatic logic is_alu_class(input logic [WORD_SIZE-1:0] op);
        return (op[7:6] == 2'b10) || ((op[7:6] == 2'b11) && (op[2:0] == 3'b110));
    endfunction

    // Operand field 6 selects (HL) or an immediate byte, so the ALU works in
    // the cycle after the operand arrives rather than on entry to EXEC.
    function automatic logic is_mem_form(input logic [WORD_SIZE-1:0] op);
        return op[2:0] == 3'b110;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; the combinational blocks below use blocking (=).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            opcode_q       <= '0;
            bank_cb_q      <= 1'b0;
            in_halt_q      <= 1'b0;
            in_alu_q       <= 1'b0;
            pc_hold_q      <= 1'b0;
            operand_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            bank_cb_q      <= bank_cb_d;
            in_halt_q      <= in_halt_d;
            in_alu_q       <= in_alu_d;
            pc_hold_q      <= pc_hold_d;
            operand_seen_q <= operand_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        opcode_d       = opcode_q;
        bank_cb_d      = bank_cb_q;
        in_halt_d      = in_halt_q;
        in_alu_d       = 1'b0;       // single-cycle pulse by construction
        pc_hold_d      = pc_hold_q;
        operand_seen_d = operand_seen_q;

        unique case (state_q)
            ST_FETCH: begin
                if (bus.data_valid) begin
                    opcode_d       = bus.data_in;
                    bank_cb_d      = 1'b0;
                    pc_hold_d      = 1'b0;   // the held byte has now been taken
                    operand_seen_d = 1'b0;
                    if (bus.data_in == OP_PREFIX_CB) begin
                        state_d = ST_CB_FETCH;
                    end else begin
                        state_d  = ST_EXEC;
                        // r-form pulses on the first EXEC cycle, i.e. right
                        // after this accepting edge.
                        in_alu_d = is_alu_class(bus.data_in) && !is_mem_form(bus.data_in);
                    end
                end
            end

            ST_CB_FETCH: begin
                // opcode_q still shows 0xCB here so the decoder sees the prefix.
                // Any byte, including a second 0xCB, is a bank-1 opcode and
                // bank-1 opcodes never raise in_alu.
                if (bus.data_valid) begin
                    opcode_d       = bus.data_in;
                    bank_cb_d      = 1'b1;
                    operand_seen_d = 1'b0;
                    state_d        = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // instr_end has priority; a coincident operand byte is dropped.
                if (bus.instr_end) begin
                    if ((opcode_q == OP_HALT) && !bank_cb_q) begin
`ifdef SM83_HALT_BUG_EN
                        if (!bus.ime && bus.irq) begin
                            state_d   = ST_FETCH;
                            pc_hold_d = 1'b1;
                        end else begin
                            state_d   = ST_HALT;
                            in_halt_d = 1'b1;
                        end
`else
                        state_d   = ST_HALT;
                        in_halt_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (bus.data_valid && !operand_seen_q) begin
                    operand_seen_d = 1'b1;
                    in_alu_d       = !bank_cb_q && is_alu_class(opcode_q) && is_mem_form(opcode_q);
                end
            end

            ST_HALT: begin
                // Level-sensitive wake-up; data_valid is ignored while halted.
                if (bus.irq) begin
                    in_halt_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

`ifndef SM83_HALT_BUG_EN
    // ime only matters for the HALT bug; keep it visibly consumed.
    logic ime_unused;
    assign ime_unused = bus.ime;
`endif

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.m1           = (state_q == ST_FETCH) || (state_q == ST_CB_FETCH);
        bus.opcode_valid = (state_q == ST_EXEC);
    end

    assign bus.opcode  = opcode_q;
    assign bus.bank_cb = bank_cb_q;
    assign bus.in_halt = in_halt_q;
    assign bus.in_alu  = in_alu_q;
    assign bus.pc_hold = pc_hold_q;

endmodule
